// File: rtl/mas_prog_loader.sv
// Boot/programming controller for the MAS16bA core.
// Buffers a program received over a valid/ready stream, then drives the
// core through reset -> programming burst -> reset -> run. Every output is
// registered and derived from the next state, so there is no combinational
// path from any input to any output.
module mas_prog_loader #(
    parameter int DEPTH      = 64,  // max program length in words (power of two, >= 2)
    parameter int CW         = 7,   // counter width, 2**CW > DEPTH
    parameter int RST_CYCLES = 2    // core reset length per reset phase, >= 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          s_valid,
    input  logic [15:0]   s_data,
    input  logic          s_last,
    output logic          s_ready,
    output logic          pg,
    output logic [15:0]   pg_instr,
    output logic          cpu_rstz,
    output logic          busy,
    output logic          done,
    output logic          trunc,
    output logic [CW-1:0] word_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(RST_CYCLES) + 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PRERST,
        BURST,
        POSTRST,
        RUN
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] wc_q, wc_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          trunc_q, trunc_d;
    logic [15:0]   instr_d;
    logic [15:0]   instr_q;
    logic          s_ready_q, pg_q, rstz_q, busy_q, done_q;
    logic          accept;
    logic [AW-1:0] rd_next;
    logic          burst_last;
    logic          tmr_last;

    logic [15:0]   mem_q [DEPTH];

    assign accept     = (state_q == LOAD) && s_valid && s_ready_q;
    assign rd_next    = rd_q + AW'(1);
    assign burst_last = ({{(CW-AW){1'b0}}, rd_q} == (wc_q - CW'(1)));
    assign tmr_last   = (tmr_q == TW'(RST_CYCLES - 1));

    // Program buffer write port: one word per accepted transfer.
    // NOTE: the buffer has no reset; its contents only matter after a load
    // has written them, and leaving it out keeps it mappable to plain RAM.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wc_q[AW-1:0]] <= s_data;
        end
    end

    // Next-state logic: sequencing, word counting and burst read indexing.
    // NOTE: every signal gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        wc_d    = wc_q;
        rd_d    = rd_q;
        tmr_d   = tmr_q;
        trunc_d = trunc_q;
        instr_d = '0;
        case (state_q)
            IDLE, RUN: begin
                if (start) begin
                    state_d = LOAD;
                    wc_d    = '0;
                    trunc_d = 1'b0;
                end
            end
            LOAD: begin
                if (accept) begin
                    wc_d = wc_q + CW'(1);
                    if (s_last) begin
                        state_d = PRERST;
                        tmr_d   = '0;
                    end else if (wc_q == CW'(DEPTH - 1)) begin
                        // Buffer full without an end marker: cut the program here.
                        state_d = PRERST;
                        tmr_d   = '0;
                        trunc_d = 1'b1;
                    end
                end
            end
            PRERST: begin
                if (tmr_last) begin
                    state_d = BURST;
                    rd_d    = '0;
                    instr_d = mem_q[0];
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            BURST: begin
                if (burst_last) begin
                    state_d = POSTRST;
                    tmr_d   = '0;
                end else begin
                    rd_d    = rd_next;
                    instr_d = mem_q[rd_next];
                end
            end
            POSTRST: begin
                if (tmr_last) begin
                    state_d = RUN;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; outputs follow the state being entered.
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            wc_q      <= '0;
            rd_q      <= '0;
            tmr_q     <= '0;
            trunc_q   <= 1'b0;
            instr_q   <= '0;
            s_ready_q <= 1'b0;
            pg_q      <= 1'b0;
            rstz_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wc_q      <= wc_d;
            rd_q      <= rd_d;
            tmr_q     <= tmr_d;
            trunc_q   <= trunc_d;
            instr_q   <= instr_d;
            s_ready_q <= (state_d == LOAD);
            pg_q      <= (state_d == BURST);
            rstz_q    <= (state_d == BURST) || (state_d == RUN);
            busy_q    <= (state_d != IDLE) && (state_d != RUN);
            done_q    <= (state_d == RUN);
        end
    end

    assign s_ready    = s_ready_q;
    assign pg         = pg_q;
    assign pg_instr   = instr_q;
    assign cpu_rstz   = rstz_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign trunc      = trunc_q;
    assign word_count = wc_q;

endmodule

// File: tb/tb_mas_prog_loader.sv
// Directed bench for mas_prog_loader: basic, stalled, single-word,
// truncated, reload-from-RUN, start-in-BURST and reset-in-BURST sequences.
module tb_mas_prog_loader;

    logic        clk = 1'b0;
    logic        rst, start, s_valid, s_last;
    logic [15:0] s_data;
    logic        s_ready, pg, cpu_rstz, busy, done, trunc;
    logic [15:0] pg_instr;
    logic [6:0]  word_count;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_words [70];

    mas_prog_loader #(.DEPTH(64), .CW(7), .RST_CYCLES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .pg         (pg),
        .pg_instr   (pg_instr),
        .cpu_rstz   (cpu_rstz),
        .busy       (busy),
        .done       (done),
        .trunc      (trunc),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one word after 'gap' idle cycles; junk data/last during the gap.
    task automatic send(input logic [15:0] data, input logic last, input int gap);
        s_valid = 1'b0;
        s_data  = 16'hFFFF;
        s_last  = 1'b1;
        repeat (gap) step();
        check("s_ready_before_word", 32'(s_ready), 1);
        s_valid = 1'b1;
        s_data  = data;
        s_last  = last;
        step();
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = 16'hDEAD;
    endtask

    // Called on the first PRERST cycle; checks the rest of the sequence into RUN.
    task automatic check_tail(input int n, input logic exp_trunc, input int start_at);
        for (int i = 0; i < 2; i++) begin
            check("prerst_pg", 32'(pg), 0);
            check("prerst_rstz", 32'(cpu_rstz), 0);
            check("prerst_busy", 32'(busy), 1);
            step();
        end
        for (int k = 0; k < n; k++) begin
            check("burst_pg", 32'(pg), 1);
            check("burst_rstz", 32'(cpu_rstz), 1);
            check("burst_instr", 32'(pg_instr), 32'(exp_words[k]));
            if (k == start_at) start = 1'b1;
            step();
            start = 1'b0;
        end
        for (int i = 0; i < 2; i++) begin
            check("postrst_pg", 32'(pg), 0);
            check("postrst_instr", 32'(pg_instr), 0);
            check("postrst_rstz", 32'(cpu_rstz), 0);
            check("postrst_done", 32'(done), 0);
            step();
        end
        check("run_done", 32'(done), 1);
        check("run_rstz", 32'(cpu_rstz), 1);
        check("run_busy", 32'(busy), 0);
        check("run_pg", 32'(pg), 0);
        check("run_s_ready", 32'(s_ready), 0);
        check("run_word_count", 32'(word_count), 32'(n));
        check("run_trunc", 32'(trunc), 32'(exp_trunc));
    endtask

    // Pulse start from RUN and check the immediate reload response.
    task automatic reload();
        start = 1'b1;
        step();
        start = 1'b0;
        check("reload_rstz", 32'(cpu_rstz), 0);
        check("reload_done", 32'(done), 0);
        check("reload_s_ready", 32'(s_ready), 1);
        check("reload_busy", 32'(busy), 1);
        check("reload_word_count", 32'(word_count), 0);
        check("reload_trunc", 32'(trunc), 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
        step();
        step();
        check("rst_pg", 32'(pg), 0);
        check("rst_instr", 32'(pg_instr), 0);
        check("rst_rstz", 32'(cpu_rstz), 0);
        check("rst_s_ready", 32'(s_ready), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_trunc", 32'(trunc), 0);
        check("rst_word_count", 32'(word_count), 0);
        rst = 1'b0;
        step();
        check("idle_s_ready", 32'(s_ready), 0);

        // Basic 3-word load, no gaps.
        start = 1'b1;
        step();
        start = 1'b0;
        check("load_s_ready", 32'(s_ready), 1);
        check("load_busy", 32'(busy), 1);
        check("load_rstz", 32'(cpu_rstz), 0);
        exp_words[0] = 16'h1111; exp_words[1] = 16'h2222; exp_words[2] = 16'h3333;
        send(16'h1111, 1'b0, 0);
        check("load_word_count1", 32'(word_count), 1);
        send(16'h2222, 1'b0, 0);
        send(16'h3333, 1'b1, 0);
        check("after_last_s_ready", 32'(s_ready), 0);
        check("after_last_word_count", 32'(word_count), 3);
        check_tail(3, 1'b0, -1);

        // Reload from RUN, stalled source with 5 idle cycles between words.
        reload();
        exp_words[0] = 16'hA001; exp_words[1] = 16'hA002; exp_words[2] = 16'hA003;
        send(16'hA001, 1'b0, 0);
        send(16'hA002, 1'b0, 5);
        send(16'hA003, 1'b1, 5);
        check_tail(3, 1'b0, -1);

        // Single-word program: BURST of one cycle, RUN after 2+1+2 cycles.
        reload();
        exp_words[0] = 16'hABCD;
        send(16'hABCD, 1'b1, 0);
        check_tail(1, 1'b0, -1);

        // Truncation: 64 words without s_last, source keeps offering more.
        reload();
        for (int i = 0; i < 64; i++) begin
            exp_words[i] = 16'h5000 + 16'(i);
            send(16'h5000 + 16'(i), 1'b0, 0);
        end
        s_valid = 1'b1;
        s_data  = 16'h5040;
        check("trunc_s_ready_low", 32'(s_ready), 0);
        check("trunc_word_count", 32'(word_count), 64);
        check("trunc_flag", 32'(trunc), 1);
        check_tail(64, 1'b1, -1);
        s_valid = 1'b0;

        // Start pulse in BURST cycle 1 must be ignored.
        reload();
        exp_words[0] = 16'hB000; exp_words[1] = 16'hB001;
        exp_words[2] = 16'hB002; exp_words[3] = 16'hB003;
        for (int i = 0; i < 4; i++) send(exp_words[i], (i == 3), 0);
        check_tail(4, 1'b0, 1);

        // Reset asserted in BURST cycle 2 of a 4-word program.
        reload();
        exp_words[0] = 16'hC000; exp_words[1] = 16'hC001;
        exp_words[2] = 16'hC002; exp_words[3] = 16'hC003;
        for (int i = 0; i < 4; i++) send(exp_words[i], (i == 3), 0);
        step();
        step();
        check("rb_burst0", 32'(pg_instr), 32'hC000);
        step();
        check("rb_burst1", 32'(pg_instr), 32'hC001);
        step();
        check("rb_burst2", 32'(pg_instr), 32'hC002);
        check("rb_burst2_pg", 32'(pg), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rb_pg", 32'(pg), 0);
        check("rb_rstz", 32'(cpu_rstz), 0);
        check("rb_busy", 32'(busy), 0);
        check("rb_done", 32'(done), 0);
        check("rb_word_count", 32'(word_count), 0);
        check("rb_instr", 32'(pg_instr), 0);
        check("rb_s_ready", 32'(s_ready), 0);
        step();
        check("rb_idle_pg", 32'(pg), 0);
        check("rb_idle_busy", 32'(busy), 0);

        // Controller is usable again after the abort.
        start = 1'b1;
        step();
        start = 1'b0;
        check("rb_restart_s_ready", 32'(s_ready), 1);
        exp_words[0] = 16'h0F0F;
        send(16'h0F0F, 1'b1, 2);
        check_tail(1, 1'b0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mas_prog_loader.md
Name: mas_prog_loader

Overview:
- Boot/programming controller for the MAS16bA core; sequences the core's pg, pg_instr and rstz inputs.
- Accepts a program as a stream of 16-bit instruction words over a valid/ready handshake and buffers the whole program internally.
- Replays the program contiguously, one word per cycle, while the core is in programming mode. The core's PC advances by 2 every cycle when pg=1, so gaps are not allowed.
- Then resets the core so its PC returns to 0x8000 and releases it to run.

Parameters:
- DEPTH, 64, maximum program length in words; power of two, ≥2.
- CW, 7, counter width; must satisfy 2^CW > DEPTH.
- RST_CYCLES, 2, cycles the core reset is held in each reset phase; ≥1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle load request.
- s_valid  in  1  source word valid.
- s_data  in  16  source instruction word.
- s_last  in  1  marks the final word of the program.
- s_ready  out  1  loader can accept a word.
- pg  out  1  drives the core's pg input.
- pg_instr  out  16  drives the core's pg_instr input.
- cpu_rstz  out  1  drives the core's rstz input (active-low).
- busy  out  1  high in any state except IDLE and RUN.
- done  out  1  high in RUN.
- trunc  out  1  sticky: program was cut at DEPTH words.
- word_count  out  CW  number of words accepted in the current load.

Behaviour:
- Reset (rst=1 at a clk edge) is synchronous:
  - state=IDLE.
  - pg=0, pg_instr=0, cpu_rstz=0, s_ready=0, busy=0, done=0, trunc=0, word_count=0.
  - Buffer contents are don't-care.
  - A reset in mid-operation (including mid-BURST) aborts immediately with the same values. A partially written core memory is acceptable.
- All outputs are registered; no combinational input-to-output path.
- States: IDLE, LOAD, PRERST, BURST, POSTRST, RUN.
- IDLE:
  - cpu_rstz=0, pg=0.
  - start=1 -> LOAD next cycle; word_count and trunc are cleared on that same edge.
- LOAD:
  - s_ready=1 while word_count<DEPTH.
  - A word is accepted when s_valid&&s_ready: buf[word_count]<=s_data, word_count++.
  - Accepting a word with s_last=1 -> PRERST; s_ready=0 from the next cycle.
  - Accepting word number DEPTH with s_last=0 -> trunc<=1, then PRERST. Further source words are not accepted.
  - start is ignored.
- PRERST:
  - cpu_rstz=0, pg=0 for exactly RST_CYCLES cycles, so the core's PC is loaded to 0x8000.
  - pg must stay 0 while cpu_rstz=0; otherwise the core clears its memory.
- BURST:
  - Lasts exactly word_count cycles; cycle k (0-based) drives pg=1, cpu_rstz=1, pg_instr=buf[k].
  - No stalls or bubbles. Word k lands at core address 0x8000+2k.
- POSTRST:
  - On the cycle after the last BURST word, pg=0, pg_instr=0, cpu_rstz=0 for RST_CYCLES cycles.
  - pg falls no later than cpu_rstz, i.e. on the same edge.
- RUN:
  - cpu_rstz=1, pg=0, done=1.
  - start=1 -> LOAD. cpu_rstz=0 from the next cycle; done=0, word_count=0, trunc=0.
- Start during LOAD, PRERST, BURST or POSTRST has no effect.
- s_data/s_last are sampled only on an accepted transfer. s_valid may toggle freely, and idle source cycles in LOAD are allowed.
- Minimum program is 1 word, giving BURST of 1 cycle. A word_count of 0 cannot reach BURST.
- Total load-to-RUN latency after the last accepted word: RST_CYCLES + N + RST_CYCLES cycles.

Test Plan:
- Reset mid-BURST: 4-word program, assert rst in BURST cycle 2 -> next cycle IDLE, pg=0, cpu_rstz=0, busy=0, word_count=0.
- Basic 3-word load: start; s_data=0x1111,0x2222,0x3333 (last on 3rd) with no gaps ->
  - PRERST 2 cycles, cpu_rstz=0, pg=0;
  - BURST 3 cycles, pg=1, pg_instr=0x1111,0x2222,0x3333;
  - POSTRST 2 cycles;
  - RUN with done=1, word_count=3, trunc=0.
  - With the core attached: mem[0x8000..0x8004] = those words and PC=0x8000 on release.
- Stalled source: 3 words with s_valid low for 5 cycles between each -> BURST is still 3 back-to-back cycles with identical pg_instr sequence.
- Truncation: DEPTH=64, stream 70 words, never asserting s_last -> s_ready low after word 64; trunc=1; BURST lasts 64 cycles; last pg_instr=word 63.
- Single-word program: 0xABCD with s_last -> BURST is 1 cycle, pg_instr=0xABCD; done=1 after 2+1+2 cycles.
- Reload from RUN: start in RUN -> cpu_rstz=0 and done=0 on the next cycle, s_ready=1. A start asserted during BURST is ignored: the state sequence and pg_instr sequence are unchanged.
